// File: rtl/branch_resolve_pht.sv
// EXE-stage branch resolver: evaluates branch conditions, checks the IF direction
// prediction, emits registered flush pulses and maintains the 2-bit PHT read by IF.
module branch_resolve_pht #(
  parameter int         DATA_W    = 32,
  parameter int         PC_W      = 32,
  parameter int         PHT_IDX_W = 6,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         STAT_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exe_valid,
  input  logic              exe_stall,
  input  logic              exe_kill,
  input  logic              exe_is_branch,
  input  logic [2:0]        exe_branch_code,
  input  logic              exe_is_likely,
  input  logic [DATA_W-1:0] exe_op_a,
  input  logic [DATA_W-1:0] exe_op_b,
  input  logic [PC_W-1:0]   exe_pc,
  input  logic              exe_pred_taken,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic              resolve_valid,
  output logic              resolve_taken,
  output logic              branch_flush,
  output logic              delayslot_flush,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam logic signed [DATA_W-1:0] ZERO = '0;

  logic [1:0]            pht_reg [PHT_N];
  logic [STAT_W-1:0]     mispredict_cnt_reg;
  logic                  resolve_valid_reg;
  logic                  resolve_taken_reg;
  logic                  branch_flush_reg;
  logic                  delayslot_flush_reg;

  logic signed [DATA_W-1:0] op_a_s;
  logic                  fire;
  logic                  is_jr;
  logic                  taken;
  logic                  mispredict;
  logic                  pht_we;
  logic [PHT_IDX_W-1:0]  exe_idx;
  logic [PHT_IDX_W-1:0]  if_idx;
  logic [1:0]            cnt_cur;
  logic [1:0]            cnt_next;

  assign op_a_s  = exe_op_a;
  assign exe_idx = exe_pc[PHT_IDX_W+1:2];
  assign if_idx  = if_pc[PHT_IDX_W+1:2];

  // Stall and kill gate the pulse so a held branch resolves exactly once, on release.
  assign fire = exe_valid & exe_is_branch & ~exe_stall & ~exe_kill & (exe_branch_code != 3'd7);
  assign is_jr = (exe_branch_code == 3'd6);

  always_comb begin
    taken = 1'b0;
    case (exe_branch_code)
      3'd0:    taken = (exe_op_a == exe_op_b);
      3'd1:    taken = (exe_op_a != exe_op_b);
      3'd2:    taken = (op_a_s >= ZERO);
      3'd3:    taken = (op_a_s >  ZERO);
      3'd4:    taken = (op_a_s <= ZERO);
      3'd5:    taken = (op_a_s <  ZERO);
      3'd6:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // JR targets are never predicted, so a JR always redirects fetch.
  assign mispredict = is_jr | (taken ^ exe_pred_taken);
  assign pht_we     = fire & ~is_jr;

  assign cnt_cur = pht_reg[exe_idx];

  always_comb begin
    cnt_next = cnt_cur;
    if (taken) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
    end
  end

  // Prediction reads the stored value, so a same-cycle update shows up one cycle later.
  assign if_pred_taken = pht_reg[if_idx][1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PHT_N; i++) pht_reg[i] <= CNT_INIT;
    end else if (pht_we) begin
      pht_reg[exe_idx] <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resolve_valid_reg   <= 1'b0;
      resolve_taken_reg   <= 1'b0;
      branch_flush_reg    <= 1'b0;
      delayslot_flush_reg <= 1'b0;
      mispredict_cnt_reg  <= '0;
    end else begin
      resolve_valid_reg   <= fire;
      resolve_taken_reg   <= fire & taken;
      branch_flush_reg    <= fire & mispredict;
      delayslot_flush_reg <= fire & exe_is_likely & ~taken;
      if (fire && mispredict && (mispredict_cnt_reg != {STAT_W{1'b1}}))
        mispredict_cnt_reg <= mispredict_cnt_reg + STAT_W'(1);
    end
  end

  assign resolve_valid   = resolve_valid_reg;
  assign resolve_taken   = resolve_taken_reg;
  assign branch_flush    = branch_flush_reg;
  assign delayslot_flush = delayslot_flush_reg;
  assign mispredict_cnt  = mispredict_cnt_reg;

  // PC bits outside the index field do not take part in PHT addressing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{exe_pc[PC_W-1:PHT_IDX_W+2], exe_pc[1:0],
                            if_pc[PC_W-1:PHT_IDX_W+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_pht.sv
// Directed bench for branch_resolve_pht: a 32-bit instance for the main sequence and a
// 64-bit / 4-bit-statistics instance for wide operands and counter saturation.
module tb_branch_resolve_pht;

  typedef struct {
    logic taken;
    logic bflush;
    logic dflush;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        exe_valid;
  logic        v64;
  logic        exe_stall;
  logic        exe_kill;
  logic        exe_is_branch;
  logic [2:0]  exe_branch_code;
  logic        exe_is_likely;
  logic [63:0] exe_op_a;
  logic [63:0] exe_op_b;
  logic [31:0] exe_pc;
  logic        exe_pred_taken;
  logic [31:0] if_pc;

  logic        pred32, rv32, rt32, bf32, df32;
  logic [15:0] mc32;
  logic        pred64, rv64, rt64, bf64, df64;
  logic [3:0]  mc64;

  exp_t q32[$];
  exp_t q64[$];
  int   total = 0;
  int   bad   = 0;

  branch_resolve_pht dut32 (
    .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .exe_stall(exe_stall),
    .exe_kill(exe_kill), .exe_is_branch(exe_is_branch), .exe_branch_code(exe_branch_code),
    .exe_is_likely(exe_is_likely), .exe_op_a(exe_op_a[31:0]), .exe_op_b(exe_op_b[31:0]),
    .exe_pc(exe_pc), .exe_pred_taken(exe_pred_taken), .if_pc(if_pc),
    .if_pred_taken(pred32), .resolve_valid(rv32), .resolve_taken(rt32),
    .branch_flush(bf32), .delayslot_flush(df32), .mispredict_cnt(mc32)
  );

  branch_resolve_pht #(.DATA_W(64), .STAT_W(4)) dut64 (
    .clk(clk), .resetn(resetn), .exe_valid(v64), .exe_stall(exe_stall),
    .exe_kill(exe_kill), .exe_is_branch(exe_is_branch), .exe_branch_code(exe_branch_code),
    .exe_is_likely(exe_is_likely), .exe_op_a(exe_op_a), .exe_op_b(exe_op_b),
    .exe_pc(exe_pc), .exe_pred_taken(exe_pred_taken), .if_pc(if_pc),
    .if_pred_taken(pred64), .resolve_valid(rv64), .resolve_taken(rt64),
    .branch_flush(bf64), .delayslot_flush(df64), .mispredict_cnt(mc64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    exe_valid = 1'b0; v64 = 1'b0; exe_stall = 1'b0; exe_kill = 1'b0;
    exe_is_branch = 1'b0; exe_branch_code = 3'd7; exe_is_likely = 1'b0;
    exe_op_a = 'x; exe_op_b = 'x; exe_pc = '0; exe_pred_taken = 1'b0;
  endtask

  task automatic br(input logic [2:0] code, input logic [63:0] a, input logic [63:0] b,
                    input logic [31:0] pc, input logic pred, input logic likely);
    exe_valid = 1'b1; exe_is_branch = 1'b1; exe_branch_code = code;
    exe_op_a = a; exe_op_b = b; exe_pc = pc; exe_pred_taken = pred; exe_is_likely = likely;
  endtask

  task automatic push32(input logic t, input logic bf, input logic df);
    exp_t e;
    e.taken = t; e.bflush = bf; e.dflush = df;
    q32.push_back(e);
  endtask

  task automatic push64(input logic t, input logic bf, input logic df);
    exp_t e;
    e.taken = t; e.bflush = bf; e.dflush = df;
    q64.push_back(e);
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  // One clock: decide which instances should fire, then check their registered outputs.
  task automatic cycle();
    logic f32, f64;
    exp_t e;
    f32 = exe_valid && exe_is_branch && !exe_stall && !exe_kill && (exe_branch_code != 3'd7);
    f64 = v64 && exe_is_branch && !exe_stall && !exe_kill && (exe_branch_code != 3'd7);
    @(posedge clk);
    #1;
    if (f32) begin
      total++;
      assert (q32.size() != 0) else begin
        bad++;
        $error("FAIL q32_empty observed=0 expected=1");
      end
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("rv32", rv32, 1'b1);
        chk("taken32", rt32, e.taken);
        chk("bflush32", bf32, e.bflush);
        chk("dflush32", df32, e.dflush);
      end
    end else begin
      chk("idle32", {rv32, rt32, bf32, df32}, 4'b0000);
    end
    if (f64) begin
      total++;
      assert (q64.size() != 0) else begin
        bad++;
        $error("FAIL q64_empty observed=0 expected=1");
      end
      if (q64.size() != 0) begin
        e = q64.pop_front();
        chk("rv64", rv64, 1'b1);
        chk("taken64", rt64, e.taken);
        chk("bflush64", bf64, e.bflush);
        chk("dflush64", df64, e.dflush);
      end
    end else begin
      chk("idle64", {rv64, rt64, bf64, df64}, 4'b0000);
    end
  endtask

  initial begin
    idle();
    if_pc  = 32'h100;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs32", {rv32, rt32, bf32, df32}, 4'b0000);
    chk("rst_cnt32", mc32, 16'd0);
    chk("rst_pred32", pred32, 1'b0);
    chk("rst_cnt64", mc64, 4'd0);
    resetn = 1'b1;

    // BEQ taken, predicted not-taken: PHT[0] 01->10
    br(3'd0, 64'h5, 64'h5, 32'h100, 1'b0, 1'b0);
    look(32'h100);
    chk("t1_pred_pre", pred32, 1'b0);
    push32(1'b1, 1'b1, 1'b0); cycle(); idle();
    chk("t1_cnt", mc32, 16'd1);
    chk("t1_pred_post", pred32, 1'b1);
    $display("t1 BEQ taken mispredict: cnt=%0d pred=%0b", mc32, pred32);

    // BLTZ held by a 3-cycle stall resolves once on release: PHT[0] 10->11
    br(3'd5, 64'h8000_0000, 64'h0, 32'h100, 1'b1, 1'b0);
    exe_stall = 1'b1;
    repeat (3) cycle();
    exe_stall = 1'b0;
    push32(1'b1, 1'b0, 1'b0); cycle(); idle();
    chk("t2_cnt", mc32, 16'd1);
    br(3'd3, 64'h1, 64'h0, 32'h100, 1'b1, 1'b0);
    push32(1'b1, 1'b0, 1'b0); cycle(); idle();
    br(3'd0, 64'h1, 64'h2, 32'h100, 1'b1, 1'b0);
    push32(1'b0, 1'b1, 1'b0); cycle(); idle();
    chk("t2_cnt2", mc32, 16'd2);
    look(32'h100);
    chk("t2_sat_hi", pred32, 1'b1);
    br(3'd1, 64'h3, 64'h3, 32'h100, 1'b1, 1'b0);
    push32(1'b0, 1'b1, 1'b0); cycle(); idle();
    chk("t2_cnt3", mc32, 16'd3);
    chk("t2_dec", pred32, 1'b0);
    $display("t2 stalled BLTZ and saturation: cnt=%0d", mc32);

    // Branch-likely: not taken kills delay slot, taken keeps it
    br(3'd0, 64'h1, 64'h2, 32'h204, 1'b0, 1'b1);
    push32(1'b0, 1'b0, 1'b1); cycle(); idle();
    chk("t3_cnt", mc32, 16'd3);
    br(3'd0, 64'h1, 64'h2, 32'h204, 1'b1, 1'b1);
    push32(1'b0, 1'b1, 1'b1); cycle(); idle();
    chk("t3_cnt2", mc32, 16'd4);
    br(3'd1, 64'h1, 64'h2, 32'h204, 1'b1, 1'b1);
    push32(1'b1, 1'b0, 1'b0); cycle(); idle();
    chk("t3_cnt3", mc32, 16'd4);
    $display("t3 likely branches: cnt=%0d", mc32);

    // JR always mispredicts and leaves PHT[2] at 01
    br(3'd6, 64'h0, 64'h0, 32'h108, 1'b0, 1'b0);
    push32(1'b1, 1'b1, 1'b0); cycle(); idle();
    chk("t4_cnt", mc32, 16'd5);
    look(32'h108);
    chk("t4_pred", pred32, 1'b0);
    br(3'd1, 64'h1, 64'h2, 32'h108, 1'b0, 1'b0);
    push32(1'b1, 1'b1, 1'b0); cycle(); idle();
    chk("t4_up", pred32, 1'b1);
    br(3'd0, 64'h1, 64'h2, 32'h108, 1'b1, 1'b0);
    push32(1'b0, 1'b1, 1'b0); cycle(); idle();
    chk("t4_down", pred32, 1'b0);
    chk("t4_cnt2", mc32, 16'd7);
    br(3'd6, 64'h0, 64'h0, 32'h108, 1'b0, 1'b0);
    exe_kill = 1'b1;
    cycle(); idle();
    br(3'd7, 64'h0, 64'h0, 32'h108, 1'b0, 1'b0);
    cycle(); idle();
    chk("t4_kill_cnt", mc32, 16'd7);
    chk("t4_kill_pred", pred32, 1'b0);
    $display("t4 JR, killed JR, code 7: cnt=%0d", mc32);

    // Same-cycle lookup and update of PHT[3]
    br(3'd2, 64'h0, 64'h0, 32'h10C, 1'b0, 1'b0);
    look(32'h10C);
    chk("t5_same_cycle", pred32, 1'b0);
    push32(1'b1, 1'b1, 1'b0); cycle();
    chk("t5_next_cycle", pred32, 1'b1);
    idle();
    chk("t5_cnt", mc32, 16'd8);

    // Asynchronous reset while outputs are high and a branch is stalled
    br(3'd4, 64'h5, 64'h0, 32'h100, 1'b1, 1'b0);
    push32(1'b0, 1'b1, 1'b0); cycle();
    exe_stall = 1'b1;
    chk("t5_pre_rst", {rv32, bf32}, 2'b11);
    #1;
    resetn = 1'b0;
    #1;
    chk("t5_rst_outs", {rv32, rt32, bf32, df32}, 4'b0000);
    chk("t5_rst_cnt", mc32, 16'd0);
    look(32'h10C);
    chk("t5_rst_pht", pred32, 1'b0);
    exe_stall = 1'b0;
    br(3'd0, 64'h5, 64'h5, 32'h100, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_rst_hold", {rv32, mc32}, 17'd0);
    resetn = 1'b1;
    push32(1'b1, 1'b1, 1'b0); cycle(); idle();
    chk("t5_release_cnt", mc32, 16'd1);
    look(32'h100);
    chk("t5_cnt_init", pred32, 1'b1);
    $display("t5 reset mid-stream and release fire: cnt=%0d", mc32);

    // 64-bit operands and 4-bit statistics saturation
    idle(); v64 = 1'b1; exe_is_branch = 1'b1;
    exe_branch_code = 3'd3; exe_op_a = 64'h1; exe_op_b = '0; exe_pred_taken = 1'b1;
    push64(1'b1, 1'b0, 1'b0); cycle();
    exe_op_a = 64'h0000_0001_0000_0000; exe_pred_taken = 1'b0;
    push64(1'b1, 1'b1, 1'b0); cycle();
    exe_branch_code = 3'd5; exe_op_a = 64'h8000_0000_0000_0000;
    push64(1'b1, 1'b1, 1'b0); cycle();
    exe_branch_code = 3'd2;
    push64(1'b0, 1'b0, 1'b0); cycle();
    chk("t6_cnt2", mc64, 4'd2);
    exe_branch_code = 3'd6;
    for (int i = 0; i < 13; i++) begin
      push64(1'b1, 1'b1, 1'b0); cycle();
    end
    chk("t6_cnt15", mc64, 4'd15);
    for (int i = 0; i < 4; i++) begin
      push64(1'b1, 1'b1, 1'b0); cycle();
    end
    chk("t6_sat", mc64, 4'd15);
    chk("t6_cnt32_quiet", mc32, 16'd1);
    idle();
    $display("t6 64-bit operands, 17 JR mispredicts: cnt64=%0d", mc64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_pht.md
Name: branch_resolve_pht

Overview:
- Parametrised EXE-stage branch resolver, successor to the combinational resolver.
- Evaluates branch conditions at DATA_W width and checks the outcome against the IF-stage direction prediction.
- Emits registered mispredict and branch-likely delay-slot flushes.
- Owns the pattern history table (PHT) of 2-bit saturating counters that IF reads for prediction.

Parameters:
DATA_W, 32, operand width for condition evaluation
PC_W, 32, program counter width
PHT_IDX_W, 6, log2 of PHT entry count; index = pc[PHT_IDX_W+1:2]
CNT_INIT, 2'b01, reset value of every PHT counter (weakly not-taken)
STAT_W, 16, width of mispredict statistics counter

Ports:
clk  in  1  core clock, rising edge
resetn  in  1  asynchronous active-low reset
exe_valid  in  1  EXE stage holds a valid instruction
exe_stall  in  1  EXE held this cycle; no resolution may fire
exe_kill  in  1  EXE instruction cancelled (exception/eret); suppresses resolution
exe_is_branch  in  1  instruction is branch/jump-register
exe_branch_code  in  3  0 BEQ, 1 BNE, 2 BGE(z), 3 BGT(z), 4 BLE(z), 5 BLT(z), 6 JR, 7 none
exe_is_likely  in  1  branch-likely variant
exe_op_a  in  DATA_W  operand A (rs)
exe_op_b  in  DATA_W  operand B (rt), used by BEQ/BNE only
exe_pc  in  PC_W  PC of the branch
exe_pred_taken  in  1  direction predicted at IF for this branch
if_pc  in  PC_W  IF fetch PC for prediction lookup
if_pred_taken  out  1  combinational prediction: MSB of PHT[if_pc index]
resolve_valid  out  1  registered pulse: a branch resolved last cycle
resolve_taken  out  1  registered actual direction
branch_flush  out  1  registered: flush IF/ID, redirect fetch
delayslot_flush  out  1  registered: flush delay-slot instruction
mispredict_cnt  out  STAT_W  saturating count of mispredicts

Behaviour:
- fire = exe_valid & exe_is_branch & ~exe_stall & ~exe_kill & (code != 7). Exactly one fire per branch even if EXE stalls many cycles.
- Conditions are computed in signed DATA_W arithmetic:
  - BEQ: a==b; BNE: a!=b
  - BGE: a>=0; BGT: a>0; BLE: a<=0; BLT: a<0
  - JR: always taken
- mispredict = taken != exe_pred_taken for conditional codes. JR always mispredicts, because the target is not predicted.
- Outputs are registered with 1-cycle latency. On the edge where fire=1:
  - resolve_valid<=1
  - resolve_taken<=taken
  - branch_flush<=mispredict
  - delayslot_flush<=exe_is_likely & ~taken
- On the edge where fire=0: all four outputs are set to 0 (single-cycle pulses).
- Likely branch, not taken, predicted taken: branch_flush=1 and delayslot_flush=1 in the same cycle.
- PHT update happens on the fire edge, for conditional codes only (JR does not update).
  - Index = exe_pc[PHT_IDX_W+1:2].
  - Taken: counter+1, saturating at 3. Not taken: counter-1, saturating at 0.
- Read/write same index in the same cycle: if_pred_taken returns the pre-update value. The new value is visible the next cycle.
- mispredict_cnt increments on each fire with mispredict=1 and holds at 2^STAT_W-1.
- Reset (asynchronous, any time, including mid-stall), all registers take their reset values immediately:
  - all outputs 0
  - every PHT entry = CNT_INIT
  - mispredict_cnt = 0
- A fire coincident with reset deassertion is honoured on the first rising edge after resetn=1.
- X on exe_op_* is ignored when fire=0.

Test Plan:
1. BEQ, a=b=32'h5, pred=0, pc=0x100 → next cycle resolve_valid=1, taken=1, branch_flush=1; PHT[0x40 mod 64=0] goes 01→10; mispredict_cnt=1; if_pred_taken at pc 0x100 reads 1 the following cycle.
2. BLTZ a=32'h8000_0000, pred=1, exe_stall=1 for 3 cycles then 0 → a single resolve pulse after stall release; branch_flush=0; counter 10→11; a further taken hit stays at 11.
3. BEQL a=1, b=2, pred=0 → branch_flush=0, delayslot_flush=1. Same with pred=1 → both flushes=1 in the same cycle.
4. JR with pred=0 → branch_flush=1, resolve_taken=1; PHT unchanged; exe_kill=1 on an identical JR → no pulse, counters unchanged.
5. Same-cycle IF lookup and EXE update of one index (counter 01, taken) → if_pred_taken=0 that cycle, 1 the next; resetn pulled low mid-stream → all outputs 0 and PHT entries=CNT_INIT immediately.
6. With STAT_W=4, drive 17 mispredicts → mispredict_cnt stops at 15; DATA_W=64, BGTZ a=64'h1 → taken=1.
